// File: rtl/input_conditioner_pio.sv
// input_conditioner_pio: 2-flop synchroniser plus per-bit debounce for the DE2 KEY/SW PIO inputs,
// with one-cycle key press pulses. Define KEY_IRQ_EN to add sticky edge_capture flags and irq.
module input_conditioner_pio #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_export,
    output logic [NUM_SW-1:0]   sw_export,
    output logic [NUM_KEYS-1:0] key_press
`ifdef KEY_IRQ_EN
    ,
    input  logic [NUM_KEYS-1:0] edge_clear,
    output logic [NUM_KEYS-1:0] edge_capture,
    output logic                irq
`endif
);

    localparam int N = NUM_KEYS + NUM_SW;
    // Keys idle high (released), switches idle low.
    localparam logic [N-1:0]     RST_LEVEL = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] raw_all;
    logic [N-1:0] stable_all;

    assign raw_all = {sw_raw, key_raw_n};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            logic             sync1_q;
            logic             sync2_q;
            logic             stable_q;
            logic             stable_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // A level is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    sync1_q  <= RST_LEVEL[gi];
                    sync2_q  <= RST_LEVEL[gi];
                    stable_q <= RST_LEVEL[gi];
                    cnt_q    <= '0;
                end else begin
                    sync1_q  <= raw_all[gi];
                    sync2_q  <= sync1_q;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign stable_all[gi] = stable_q;
        end
    endgenerate

    assign key_export = stable_all[NUM_KEYS-1:0];
    assign sw_export  = stable_all[N-1:NUM_KEYS];

    logic [NUM_KEYS-1:0] key_prev_q;
    logic [NUM_KEYS-1:0] key_press_q;

    // Press pulse lands the cycle after the debounced level falls; prev resets released.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            key_prev_q  <= '1;
            key_press_q <= '0;
        end else begin
            key_prev_q  <= key_export;
            key_press_q <= key_prev_q & ~key_export;
        end
    end

    assign key_press = key_press_q;

`ifdef KEY_IRQ_EN
    logic [NUM_KEYS-1:0] cap_q;
    logic [NUM_KEYS-1:0] cap_d;
    logic                irq_q;

    // A press arriving together with a clear keeps the flag set.
    assign cap_d = key_press_q | (cap_q & ~edge_clear);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cap_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            irq_q <= |cap_q;
        end
    end

    assign edge_capture = cap_q;
    assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_input_conditioner_pio.sv
// Directed self-checking bench for input_conditioner_pio with DEBOUNCE_CYCLES=4.
// The edge-capture/irq section runs only when KEY_IRQ_EN is defined.
module tb_input_conditioner_pio;

    logic        clk_clk;
    logic        reset_reset;
    logic [3:0]  key_raw_n;
    logic [17:0] sw_raw;
    logic [3:0]  key_export;
    logic [17:0] sw_export;
    logic [3:0]  key_press;
`ifdef KEY_IRQ_EN
    logic [3:0]  edge_clear;
    logic [3:0]  edge_capture;
    logic        irq;
`endif

    int n_cmp;
    int n_mis;

    input_conditioner_pio #(
        .NUM_KEYS       (4),
        .NUM_SW         (18),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .key_raw_n   (key_raw_n),
        .sw_raw      (sw_raw),
        .key_export  (key_export),
        .sw_export   (sw_export),
        .key_press   (key_press)
`ifdef KEY_IRQ_EN
        ,
        .edge_clear  (edge_clear),
        .edge_capture(edge_capture),
        .irq         (irq)
`endif
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Runs n cycles after a stimulus change, checking every cycle against hand-computed levels.
    task automatic run_check(input string tag, input int n,
                             input logic [3:0] k_before, input logic [3:0] k_after,
                             input logic [17:0] s_before, input logic [17:0] s_after,
                             input int change_at, input logic [3:0] press_val, input int press_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            check_val($sformatf("%s_key_c%0d", tag, k), 32'(key_export),
                      32'((k >= change_at) ? k_after : k_before));
            check_val($sformatf("%s_sw_c%0d", tag, k), 32'(sw_export),
                      32'((k >= change_at) ? s_after : s_before));
            check_val($sformatf("%s_press_c%0d", tag, k), 32'(key_press),
                      32'((k == press_at) ? press_val : 4'h0));
        end
        $display("txn %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        reset_reset = 1'b1;
        key_raw_n   = 4'h0;
        sw_raw      = 18'h3FFFF;
`ifdef KEY_IRQ_EN
        edge_clear  = 4'h0;
`endif

        // 1. Reset with keys held and switches high; then full latency and one F pulse.
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val($sformatf("rst_key_c%0d", k), 32'(key_export), 32'h0000000F);
            check_val($sformatf("rst_sw_c%0d", k), 32'(sw_export), 32'h00000000);
            check_val($sformatf("rst_press_c%0d", k), 32'(key_press), 32'h00000000);
        end
        $display("txn reset: 3 cycles checked");
        reset_reset = 1'b0;
        run_check("post_rst", 9, 4'hF, 4'h0, 18'h0, 18'h3FFFF, 6, 4'hF, 7);

        // Release all keys and drop switches: no pulse on release.
        key_raw_n = 4'hF;
        sw_raw    = 18'h0;
        run_check("rel_all", 9, 4'h0, 4'hF, 18'h3FFFF, 18'h0, 6, 4'h0, 0);

        // 2. Key 0 press then release.
        key_raw_n = 4'hE;
        run_check("k0_press", 9, 4'hF, 4'hE, 18'h0, 18'h0, 6, 4'h1, 7);
        key_raw_n = 4'hF;
        run_check("k0_rel", 9, 4'hE, 4'hF, 18'h0, 18'h0, 6, 4'h0, 0);

        // 3. Three-cycle glitch on sw[5] is rejected.
        sw_raw = 18'h00020;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("sw_glitch_c%0d", k), 32'(sw_export), 32'h00000000);
            if (k == 3) sw_raw = 18'h0;
        end
        $display("txn sw_glitch: 8 cycles checked");

        // Four-cycle hold is accepted at cycle 6, then released 6 cycles after the drop.
        sw_raw = 18'h00020;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check_val($sformatf("sw_hold_c%0d", k), 32'(sw_export),
                      (k >= 6 && k < 10) ? 32'h00000020 : 32'h00000000);
            check_val($sformatf("sw_hold_key_c%0d", k), 32'(key_export), 32'h0000000F);
            if (k == 4) sw_raw = 18'h0;
        end
        $display("txn sw_hold: 11 cycles checked");

        // 4. Keys 1 and 3 pressed together.
        key_raw_n = 4'h5;
        run_check("k13_press", 9, 4'hF, 4'h5, 18'h0, 18'h0, 6, 4'hA, 7);
        key_raw_n = 4'hF;
        run_check("k13_rel", 9, 4'h5, 4'hF, 18'h0, 18'h0, 6, 4'h0, 0);

        // 5. Reset two cycles into a key 2 debounce, then a fresh full latency.
        key_raw_n = 4'hB;
        run_check("k2_pre", 2, 4'hF, 4'hF, 18'h0, 18'h0, 99, 4'h0, 0);
        reset_reset = 1'b1;
        run_check("k2_in_rst", 3, 4'hF, 4'hF, 18'h0, 18'h0, 99, 4'h0, 0);
        reset_reset = 1'b0;
        run_check("k2_after_rst", 9, 4'hF, 4'hB, 18'h0, 18'h0, 6, 4'h4, 7);
        key_raw_n = 4'hF;
        run_check("k2_rel", 9, 4'hB, 4'hF, 18'h0, 18'h0, 6, 4'h0, 0);

`ifdef KEY_IRQ_EN
        // 6. Sticky capture, irq, set-beats-clear, and clear alone.
        reset_reset = 1'b1;
        tick();
        tick();
        reset_reset = 1'b0;
        check_val("irq_rst_cap", 32'(edge_capture), 32'h0);
        check_val("irq_rst_irq", 32'(irq), 32'h0);
        key_raw_n = 4'hE;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_val($sformatf("cap_c%0d", k), 32'(edge_capture), (k >= 8) ? 32'h1 : 32'h0);
            check_val($sformatf("irq_c%0d", k), 32'(irq), (k >= 9) ? 32'h1 : 32'h0);
        end
        $display("txn irq_set: 9 cycles checked");
        key_raw_n = 4'hF;
        run_check("k0_rel2", 8, 4'hE, 4'hF, 18'h0, 18'h0, 6, 4'h0, 0);
        key_raw_n = 4'hE;
        run_check("k0_press2", 7, 4'hF, 4'hE, 18'h0, 18'h0, 6, 4'h1, 7);
        edge_clear = 4'h1;
        tick();
        check_val("cap_set_wins", 32'(edge_capture), 32'h1);
        tick();
        edge_clear = 4'h0;
        check_val("cap_cleared", 32'(edge_capture), 32'h0);
        check_val("irq_lag", 32'(irq), 32'h1);
        tick();
        check_val("irq_cleared", 32'(irq), 32'h0);
        $display("txn irq_clear: done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
